// File: rtl/fifo_rd_stream_if.sv
// Stream-side bundle for fifo_rd_stream: FIFO pop interface, control and
// valid/ready output stream. master = the stream adapter, slave = its environment.
interface fifo_rd_stream_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             rempty;
  logic [WIDTH-1:0] rd_data;
  logic             rinc;
  logic             enable;
  logic             flush;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic [CNT_W-1:0] count;
  logic             busy;

  modport master (
    input  rempty, rd_data, enable, flush, ready,
    output rinc, data, valid, count, busy
  );

  modport slave (
    output rempty, rd_data, enable, flush, ready,
    input  rinc, data, valid, count, busy
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: turns empty/rinc pops into a valid/ready stream
// through a 2-entry skid buffer, with enable gating, flush and a delivered-word count.
module fifo_rd_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  fifo_rd_stream_if.master bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    BAD   = 2'd3
  } occ_t;

  occ_t             occ;
  occ_t             occ_next;
  logic [WIDTH-1:0] entry [2];
  logic             head;
  logic             tail;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             hs;
  logic             valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ <= EMPTY;
    else     occ <= occ_next;
  end

  // pop looks only at registered occupancy, so it never waits on ready
  always_comb begin
    valid    = (occ != EMPTY);
    pop      = bus.enable & ~bus.rempty & (occ != TWO) & ~bus.flush & ~rst;
    hs       = valid & bus.ready;
    occ_next = occ;
    if (bus.flush) begin
      occ_next = EMPTY;
    end else begin
      case (occ)
        EMPTY:   if (pop) occ_next = ONE;
        ONE: begin
          if (pop && !hs)      occ_next = TWO;
          else if (!pop && hs) occ_next = EMPTY;
        end
        TWO:     if (hs) occ_next = ONE;
        default: occ_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry[0] <= '0;
      entry[1] <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      count    <= '0;
    end else if (bus.flush) begin
      head <= 1'b0;
      tail <= 1'b0;
    end else begin
      if (pop) begin
        entry[tail] <= bus.rd_data;
        tail        <= ~tail;
      end
      if (hs) begin
        head  <= ~head;
        count <= count + CNT_W'(1);
      end
    end
  end

  assign bus.rinc  = pop;
  assign bus.data  = entry[head];
  assign bus.valid = valid;
  assign bus.count = count;
  assign bus.busy  = ~rst & (valid | (bus.enable & ~bus.rempty));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO emulation, directed phases plus random
// traffic, and a negedge monitor scoring the stream against a capacity-2 queue model.
module tb_fifo_rd_stream;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_rd_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned      ncheck = 0;
  int unsigned      nerr   = 0;
  logic [WIDTH-1:0] fifo_q [$];
  logic             popped;

  // reference model: words accepted from the FIFO but not yet delivered
  logic [WIDTH-1:0] exp_q [$];
  int unsigned      mcount = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    ncheck++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_fifo();
    bus.rempty  = (fifo_q.size() == 0);
    bus.rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    set_fifo();
  endtask

  // one clock: sample rinc mid-cycle, retire the FIFO head after the edge
  task automatic tick();
    @(negedge clk);
    popped = bus.rinc;
    @(posedge clk);
    #1;
    if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
    set_fifo();
  endtask

  task automatic drain();
    int unsigned n = 0;
    bus.enable = 1'b1;
    bus.ready  = 1'b1;
    bus.flush  = 1'b0;
    while ((fifo_q.size() != 0 || bus.valid) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", int'(n < 200), 1);
  endtask

  always @(negedge clk) begin
    bit exp_pop, exp_valid, exp_hs;
    if (rst) begin
      exp_q.delete();
      mcount = 0;
      chk("rst_valid", bus.valid, 0);
      chk("rst_data",  bus.data,  0);
      chk("rst_count", bus.count, 0);
      chk("rst_busy",  bus.busy,  0);
      chk("rst_rinc",  bus.rinc,  0);
    end else begin
      exp_valid = (exp_q.size() != 0);
      exp_pop   = bus.enable && !bus.rempty && exp_q.size() < 2 && !bus.flush;
      exp_hs    = exp_valid && bus.ready;
      chk("rinc",  bus.rinc,  exp_pop);
      chk("valid", bus.valid, exp_valid);
      chk("count", bus.count, mcount % (1 << CNT_W));
      chk("busy",  bus.busy,  exp_valid || (bus.enable && !bus.rempty));
      if (exp_valid) chk("data", bus.data, exp_q[0]);
      if (bus.flush) begin
        exp_q.delete();
      end else begin
        if (exp_hs) begin
          void'(exp_q.pop_front());
          mcount++;
        end
        if (exp_pop) exp_q.push_back(bus.rd_data);
      end
    end
  end

  initial begin
    int unsigned n;
    logic [CNT_W-1:0] cnt_before;
    bus.enable = 1'b0;
    bus.ready  = 1'b0;
    bus.flush  = 1'b0;
    set_fifo();
    repeat (3) tick();
    rst = 1'b0;

    // single word
    bus.enable = 1'b1;
    bus.ready  = 1'b1;
    push(8'hA5);
    drain();
    chk("count_single", bus.count, 1);

    // streaming 16 words, one pop per cycle; 17 transfers total wraps a 4-bit count to 1
    for (int unsigned i = 1; i <= 16; i++) push(WIDTH'(i));
    n = 0;
    repeat (16) begin
      tick();
      if (popped) n++;
    end
    chk("stream_rinc_run", n, 16);
    drain();
    chk("count_wrap", bus.count, 1);

    // back-pressure
    bus.ready = 1'b0;
    for (int unsigned i = 8'h11; i <= 8'h14; i++) push(WIDTH'(i));
    n = 0;
    repeat (6) begin
      tick();
      if (popped) n++;
    end
    chk("stall_pops", n, 2);
    chk("stall_head", bus.data, 8'h11);
    drain();

    // enable gating
    bus.ready = 1'b0;
    push(8'h30);
    tick();
    bus.enable = 1'b0;
    push(8'h31);
    push(8'h32);
    bus.ready = 1'b1;
    n = 0;
    repeat (4) begin
      tick();
      if (popped) n++;
    end
    chk("gated_pops", n, 0);
    chk("gated_valid", bus.valid, 0);
    drain();

    // flush from TWO
    bus.ready = 1'b0;
    push(8'h21);
    push(8'h22);
    push(8'h23);
    repeat (3) tick();
    chk("pre_flush_valid", bus.valid, 1);
    cnt_before = bus.count;
    bus.flush = 1'b1;
    bus.ready = 1'b1;
    tick();
    chk("flush_pop", popped, 0);
    bus.flush = 1'b0;
    chk("flush_valid", bus.valid, 0);
    chk("flush_count", bus.count, cnt_before);
    drain();

    // random traffic
    repeat (400) begin
      bus.enable = ($urandom_range(0, 3) != 0);
      bus.ready  = $urandom_range(0, 1);
      bus.flush  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < 8) push(WIDTH'($urandom));
      tick();
    end
    drain();

    // asynchronous reset mid-stream
    for (int unsigned i = 0; i < 8; i++) push(WIDTH'(8'h40 + i));
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.valid, 0);
    chk("async_rst_count", bus.count, 0);
    chk("async_rst_rinc",  bus.rinc,  0);
    repeat (2) tick();
    rst = 1'b0;
    drain();
    chk("fifo_empty_end", fifo_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", ncheck, nerr);
    $finish;
  end
endmodule
